// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: instruction-fetch stage.
// Owns the program counter and the IF/ID pipeline register.
// Applies redirects and halts from branch resolution, and holds on a hazard stall.
// Runs a RUN/HALT state machine.
// Optional feature macro: FETCH_PERF_CNT_EN adds saturating fetch/redirect/stall counters.
module pc_fetch_unit #(
    parameter int unsigned PC_W      = 9,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            Stall,
    input  logic            PcSel,
    input  logic [31:0]     BrPC,
    input  logic            Halt,
    input  logic            Resume,
    input  logic [31:0]     Inst_Rdata,
    output logic [PC_W-1:0] Inst_Addr,
    output logic [PC_W-1:0] Cur_PC,
    output logic [PC_W-1:0] IfId_PC,
    output logic [31:0]     IfId_Instr,
    output logic            IfId_Valid,
    output logic            Halted,
    output logic            Misalign
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     Fetch_Cnt,
    output logic [31:0]     Redirect_Cnt,
    output logic [31:0]     Stall_Cnt
`endif
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] ifid_pc_q, ifid_pc_d;
    logic [31:0]     ifid_instr_q, ifid_instr_d;
    logic            ifid_valid_q, ifid_valid_d;
    logic            misalign_q, misalign_d;

    // Only the low PC_W bits of the redirect target address instruction memory.
    logic unused_brpc_hi;
    assign unused_brpc_hi = ^BrPC[31:PC_W];

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] redir_cnt_q, redir_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction
`endif

    // Next-state logic: redirect beats stall, stall beats sequential fetch; HALT forces bubbles.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        misalign_d   = misalign_q;
`ifdef FETCH_PERF_CNT_EN
        fetch_cnt_d  = fetch_cnt_q;
        redir_cnt_d  = redir_cnt_q;
        stall_cnt_d  = stall_cnt_q;
`endif
        if (state_q == ST_RUN) begin
            if (PcSel) begin
                pc_d         = {BrPC[PC_W-1:2], 2'b00};
                ifid_instr_d = NOP_INSTR;
                ifid_valid_d = 1'b0;
                if (BrPC[1:0] != 2'b00) begin
                    misalign_d = 1'b1;
                end
                if (Halt) begin
                    state_d = ST_HALT;
                end
`ifdef FETCH_PERF_CNT_EN
                redir_cnt_d = sat_inc(redir_cnt_q);
`endif
            end else if (Stall) begin
`ifdef FETCH_PERF_CNT_EN
                stall_cnt_d = sat_inc(stall_cnt_q);
`endif
            end else begin
                pc_d         = pc_q + PC_W'(4);
                ifid_pc_d    = pc_q;
                ifid_instr_d = Inst_Rdata;
                ifid_valid_d = 1'b1;
`ifdef FETCH_PERF_CNT_EN
                fetch_cnt_d  = sat_inc(fetch_cnt_q);
`endif
            end
        end else begin
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
            if (Resume) begin
                state_d = ST_RUN;
            end
        end
    end

    // State registers with synchronous, highest-priority reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RUN;
            pc_q         <= '0;
            ifid_pc_q    <= '0;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
`ifdef FETCH_PERF_CNT_EN
            fetch_cnt_q  <= '0;
            redir_cnt_q  <= '0;
            stall_cnt_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            misalign_q   <= misalign_d;
`ifdef FETCH_PERF_CNT_EN
            fetch_cnt_q  <= fetch_cnt_d;
            redir_cnt_q  <= redir_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
`endif
        end
    end

    assign Inst_Addr  = pc_q;
    assign Cur_PC     = pc_q;
    assign IfId_PC    = ifid_pc_q;
    assign IfId_Instr = ifid_instr_q;
    assign IfId_Valid = ifid_valid_q;
    assign Halted     = (state_q == ST_HALT);
    assign Misalign   = misalign_q;
`ifdef FETCH_PERF_CNT_EN
    assign Fetch_Cnt    = fetch_cnt_q;
    assign Redirect_Cnt = redir_cnt_q;
    assign Stall_Cnt    = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit.
// The stimulus process drives one input vector per cycle and queues the state expected after that edge.
// A separate monitor pops the queue and compares against the DUT each cycle.
module tb_pc_fetch_unit;

    localparam int unsigned PC_W = 9;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] ifpc;
        logic [31:0]     instr;
        logic            valid;
        logic            halted;
        logic            mis;
        logic            is_reset;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            Stall = 1'b0;
    logic            PcSel = 1'b0;
    logic [31:0]     BrPC = '0;
    logic            Halt = 1'b0;
    logic            Resume = 1'b0;
    logic [31:0]     Inst_Rdata;
    logic [PC_W-1:0] Inst_Addr;
    logic [PC_W-1:0] Cur_PC;
    logic [PC_W-1:0] IfId_PC;
    logic [31:0]     IfId_Instr;
    logic            IfId_Valid;
    logic            Halted;
    logic            Misalign;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]     Fetch_Cnt, Redirect_Cnt, Stall_Cnt;
`endif

    exp_t  exp_q[$];
    string name_q[$];
    int    total = 0;
    int    bad   = 0;

    always #5 clk = ~clk;

    // Instruction memory model: word = 0xAAAA0000 + address.
    assign Inst_Rdata = 32'hAAAA_0000 + 32'(Inst_Addr);

    pc_fetch_unit #(.PC_W(PC_W), .NOP_INSTR(NOP)) dut (
        .clk        (clk),
        .reset      (reset),
        .Stall      (Stall),
        .PcSel      (PcSel),
        .BrPC       (BrPC),
        .Halt       (Halt),
        .Resume     (Resume),
        .Inst_Rdata (Inst_Rdata),
        .Inst_Addr  (Inst_Addr),
        .Cur_PC     (Cur_PC),
        .IfId_PC    (IfId_PC),
        .IfId_Instr (IfId_Instr),
        .IfId_Valid (IfId_Valid),
        .Halted     (Halted),
        .Misalign   (Misalign)
`ifdef FETCH_PERF_CNT_EN
        ,
        .Fetch_Cnt    (Fetch_Cnt),
        .Redirect_Cnt (Redirect_Cnt),
        .Stall_Cnt    (Stall_Cnt)
`endif
    );

    function automatic logic [31:0] d(input int unsigned p);
        return 32'hAAAA_0000 + 32'(p);
    endfunction

    function automatic exp_t mk(input int unsigned pc, input int unsigned ifpc, input logic [31:0] instr,
                                input logic valid, input logic halted, input logic mis, input logic rst);
        exp_t e;
        e.pc       = PC_W'(pc);
        e.ifpc     = PC_W'(ifpc);
        e.instr    = instr;
        e.valid    = valid;
        e.halted   = halted;
        e.mis      = mis;
        e.is_reset = rst;
        return e;
    endfunction

    // Drive one vector on the falling edge and queue the state expected after the next rising edge.
    task automatic vec(input string nm, input logic rst, input logic st, input logic ps,
                       input logic [31:0] br, input logic hl, input logic rs, input exp_t e);
        @(negedge clk);
        reset  = rst;
        Stall  = st;
        PcSel  = ps;
        BrPC   = br;
        Halt   = hl;
        Resume = rs;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: compare the DUT against the oldest expectation just after each rising edge.
    initial begin
        exp_t  e;
        exp_t  a;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a  = '{pc: Cur_PC, ifpc: IfId_PC, instr: IfId_Instr, valid: IfId_Valid,
                       halted: Halted, mis: Misalign, is_reset: e.is_reset};
                total++;
                if (a !== e || Inst_Addr !== e.pc) begin
                    bad++;
                    $display("FAIL %s: got pc=%h addr=%h ifpc=%h instr=%h v=%b h=%b m=%b, want pc=%h ifpc=%h instr=%h v=%b h=%b m=%b",
                             nm, a.pc, Inst_Addr, a.ifpc, a.instr, a.valid, a.halted, a.mis,
                             e.pc, e.ifpc, e.instr, e.valid, e.halted, e.mis);
                end
`ifdef FETCH_PERF_CNT_EN
                if (e.is_reset) begin
                    total++;
                    if (Fetch_Cnt !== 32'd0 || Redirect_Cnt !== 32'd0 || Stall_Cnt !== 32'd0) begin
                        bad++;
                        $display("FAIL %s_cnt: got f=%0d r=%0d s=%0d, want all 0",
                                 nm, Fetch_Cnt, Redirect_Cnt, Stall_Cnt);
                    end
                end
`endif
            end
        end
    end

    // Directed stimulus with hand-computed expected state.
    initial begin
        int waited;
        //       name          rst st ps br            hl rs   pc     ifpc   instr        v  h  m  r
        vec("reset",       1, 0, 0, 32'h0,       0, 0, mk(12'h000, 12'h000, NOP,          0, 0, 0, 1));
        vec("run0",        0, 0, 0, 32'h0,       0, 0, mk(12'h004, 12'h000, d(12'h000),   1, 0, 0, 0));
        vec("run1",        0, 0, 0, 32'h0,       0, 0, mk(12'h008, 12'h004, d(12'h004),   1, 0, 0, 0));
        vec("redir40",     0, 0, 1, 32'h40,      0, 0, mk(12'h040, 12'h004, NOP,          0, 0, 0, 0));
        vec("tgt40",       0, 0, 0, 32'h0,       0, 0, mk(12'h044, 12'h040, d(12'h040),   1, 0, 0, 0));
        vec("redir0c",     0, 0, 1, 32'h0C,      0, 0, mk(12'h00C, 12'h040, NOP,          0, 0, 0, 0));
        vec("tgt0c",       0, 0, 0, 32'h0,       0, 0, mk(12'h010, 12'h00C, d(12'h00C),   1, 0, 0, 0));
        vec("stall1",      0, 1, 0, 32'h0,       0, 0, mk(12'h010, 12'h00C, d(12'h00C),   1, 0, 0, 0));
        vec("stall2",      0, 1, 0, 32'h0,       0, 0, mk(12'h010, 12'h00C, d(12'h00C),   1, 0, 0, 0));
        vec("stall_redir", 0, 1, 1, 32'h80,      0, 0, mk(12'h080, 12'h00C, NOP,          0, 0, 0, 0));
        vec("tgt80",       0, 0, 0, 32'h0,       0, 0, mk(12'h084, 12'h080, d(12'h080),   1, 0, 0, 0));
        vec("halt_in",     0, 0, 1, 32'h24,      1, 0, mk(12'h024, 12'h080, NOP,          0, 1, 0, 0));
        vec("halt_ign",    0, 1, 1, 32'h0,       1, 0, mk(12'h024, 12'h080, NOP,          0, 1, 0, 0));
        vec("halt_idle",   0, 0, 0, 32'h0,       0, 0, mk(12'h024, 12'h080, NOP,          0, 1, 0, 0));
        vec("resume",      0, 0, 0, 32'h0,       0, 1, mk(12'h024, 12'h080, NOP,          0, 0, 0, 0));
        vec("post_res",    0, 0, 0, 32'h0,       0, 0, mk(12'h028, 12'h024, d(12'h024),   1, 0, 0, 0));
        vec("res_in_run",  0, 0, 0, 32'h0,       0, 1, mk(12'h02C, 12'h028, d(12'h028),   1, 0, 0, 0));
        vec("halt_nosel",  0, 0, 0, 32'h0,       1, 0, mk(12'h030, 12'h02C, d(12'h02C),   1, 0, 0, 0));
        vec("misalign",    0, 0, 1, 32'hFFFF_FE06, 0, 0, mk(12'h004, 12'h02C, NOP,        0, 0, 1, 0));
        vec("mis_sticky",  0, 0, 0, 32'h0,       0, 0, mk(12'h008, 12'h004, d(12'h004),   1, 0, 1, 0));
        vec("redir1f8",    0, 0, 1, 32'h1F8,     0, 0, mk(12'h1F8, 12'h004, NOP,          0, 0, 1, 0));
        vec("run1f8",      0, 0, 0, 32'h0,       0, 0, mk(12'h1FC, 12'h1F8, d(12'h1F8),   1, 0, 1, 0));
        vec("wrap",        0, 0, 0, 32'h0,       0, 0, mk(12'h000, 12'h1FC, d(12'h1FC),   1, 0, 1, 0));
        vec("after_wrap",  0, 0, 0, 32'h0,       0, 0, mk(12'h004, 12'h000, d(12'h000),   1, 0, 1, 0));
        vec("halt_again",  0, 0, 1, 32'h100,     1, 0, mk(12'h100, 12'h000, NOP,          0, 1, 1, 0));
        vec("reset_halt",  1, 1, 1, 32'h40,      1, 1, mk(12'h000, 12'h000, NOP,          0, 0, 0, 1));
        vec("run_after",   0, 0, 0, 32'h0,       0, 0, mk(12'h004, 12'h000, d(12'h000),   1, 0, 0, 0));

        @(negedge clk);
        Stall = 1'b0; PcSel = 1'b0; Halt = 1'b0; Resume = 1'b0;
        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Instruction-fetch stage: owns the program counter and the IF/ID pipeline register.
- Consumes the redirect request (PcSel, BrPC, Halt) produced by the branch-resolution logic in execute.
- Drives Cur_PC back to branch resolution and the address to instruction memory.
- Inserts bubbles on redirect and on halt, holds on hazard stall, and runs a RUN/HALT state machine.

Parameters:
PC_W, 9, width of program counter and instruction-memory byte address
NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0) loaded into IF/ID on flush/halt

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
Stall  input  1  hazard-unit hold request for PC and IF/ID
PcSel  input  1  redirect request; 1 = load PC from BrPC
BrPC  input  32  redirect target; only bits [PC_W-1:0] used
Halt  input  1  halt request; qualified by PcSel
Resume  input  1  leave HALT state
Inst_Rdata  input  32  instruction word at Inst_Addr, combinational read
Inst_Addr  output  PC_W  instruction-memory byte address (= Cur_PC)
Cur_PC  output  PC_W  current PC, to branch resolution
IfId_PC  output  PC_W  PC of instruction held in IF/ID
IfId_Instr  output  32  instruction held in IF/ID
IfId_Valid  output  1  1 = IF/ID holds a real instruction
Halted  output  1  1 while in HALT state
Misalign  output  1  sticky flag: a redirect target had BrPC[1:0] != 0

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port reset.
- Reset values:
  - Cur_PC = 0, IfId_PC = 0, IfId_Instr = NOP_INSTR, IfId_Valid = 0.
  - Halted = 0, Misalign = 0, state = RUN.
- Reset has priority over every other input. Reset mid-halt or mid-stall returns to these values on the next edge.
- Inst_Addr = Cur_PC, combinational. Inst_Rdata is valid in the same cycle.
- State RUN, per-edge priority (highest first):
  1. PcSel=1:
     - Cur_PC <= {BrPC[PC_W-1:2], 2'b00}.
     - IF/ID <= bubble: Valid 0, Instr NOP_INSTR, PC unchanged.
     - If BrPC[1:0] != 0, set Misalign.
     - If Halt=1, also go to HALT.
     - A redirect overrides Stall.
  2. Stall=1: Cur_PC and all IF/ID fields hold.
  3. Otherwise:
     - Cur_PC <= Cur_PC + 4, modulo 2^PC_W, so it wraps to 0 after max-4.
     - IfId_PC <= Cur_PC, IfId_Instr <= Inst_Rdata, IfId_Valid <= 1.
- Halt=1 with PcSel=0 is ignored. A halt is only honoured together with a redirect.
- State HALT:
  - Halted = 1.
  - Cur_PC holds the value loaded at entry.
  - IF/ID is forced to bubble every cycle.
  - PcSel, Stall and Halt are ignored.
  - Resume=1 → RUN on the next edge, with no fetch in that edge. Fetch restarts from the held Cur_PC on the following cycle.
  - Resume in RUN has no effect.
- Latency: redirect target appears on Cur_PC 1 cycle after PcSel is sampled. The first valid instruction from the target reaches IF/ID 2 cycles after PcSel.
- Misalign clears only on reset.
- No combinational path from any input to any output except Inst_Rdata → nothing, and Cur_PC → Inst_Addr.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, three output ports are added. All are 32-bit, reset to 0 and saturate at 32'hFFFFFFFF:
  - Fetch_Cnt: increments on every edge that loads IfId_Valid=1.
  - Redirect_Cnt: increments on every accepted PcSel in RUN.
  - Stall_Cnt: increments on every edge where Stall holds the pipeline, i.e. RUN with PcSel=0 and Stall=1.
- When not defined, the ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset then 3 free-running cycles (Stall=0, PcSel=0), Inst_Rdata = 0xAAAA0000+PC:
  - Cur_PC = 0 → 4 → 8 → 12.
  - IF/ID shows (0, 0xAAAA0000, 1), then (4, 0xAAAA0004, 1).
- Redirect: at Cur_PC=8 assert PcSel=1, BrPC=0x40 for 1 cycle:
  - next cycle Cur_PC=0x40, IfId_Valid=0, IfId_Instr=0x00000013.
  - following cycle IF/ID = (0x40, data, 1), Cur_PC=0x44.
- Stall vs redirect: Stall=1 for 2 cycles at Cur_PC=0x10 → PC and IF/ID frozen. Then Stall=1 with PcSel=1, BrPC=0x80 → Cur_PC=0x80, bubble inserted.
- Halt: PcSel=1, Halt=1, BrPC=0x24:
  - Cur_PC=0x24, Halted=1, IfId_Valid=0.
  - PcSel=1, BrPC=0x00 during HALT is ignored.
  - Resume=1 → Halted=0 next cycle; next fetch delivers IF/ID PC=0x24.
- Boundaries:
  - PcSel=1 with BrPC=0xFFFF_FE06, PC_W=9 → Cur_PC=0x004, Misalign=1, and Misalign stays 1.
  - Free-run from Cur_PC=0x1FC → wraps to 0x000.
- Reset mid-halt → all outputs return to reset values the next cycle. With FETCH_PERF_CNT_EN, counters = 0.
